// File: rtl/arbitro_pkg.sv
// -----------------------------------------------------------------------------
// arbitro_pkg
// Shared definitions for the round-robin arbiter:
//   - arb_state_e : FSM state encoding (ST_IDLE / ST_GRANT)
//   - HOLD_CNT_W  : width of the hold counter
//   - prox_req()  : circular search for the next requester, starting at ptr
// The search function works on a fixed maximum width (MAX_N / MAX_M).
// Callers zero-extend their vectors into that width and pass the real
// requester count m, which keeps one function usable for any N <= MAX_N.
// -----------------------------------------------------------------------------
package arbitro_pkg;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_GRANT = 1'b1
   } arb_state_e;

   localparam int HOLD_CNT_W = 8;

   localparam int MAX_N = 8;
   localparam int MAX_M = 1 << MAX_N;

   // Return the first index i with req[i]=1, scanning ptr, ptr+1, ... mod m.
   // m must be a power of two, so "mod m" is a mask.
   // Returns 0 when no bit is set; callers only use the result when req != 0.
   function automatic logic [MAX_N-1:0] prox_req(input logic [MAX_M-1:0] req,
                                                  input logic [MAX_N-1:0] ptr,
                                                  input int unsigned      m);
      logic [MAX_N-1:0] idx;
      logic [MAX_N-1:0] sel;
      logic             found;
      sel   = '0;
      found = 1'b0;
      for (int unsigned i = 0; i < MAX_M; i++) begin
         idx = MAX_N'((32'(ptr) + i) & (m - 1));
         if ((i < m) && !found && req[idx]) begin
            sel   = idx;
            found = 1'b1;
         end
      end
      return sel;
   endfunction

endpackage

// File: rtl/decodificador_N_M_dataflow.sv
// -----------------------------------------------------------------------------
// decodificador_N_M_dataflow
// Parametric N-to-M binary-to-one-hot decoder (M = 2^N), pure dataflow.
// Ports:
//   sel_i  [N-1:0]  binary index
//   y_o    [M-1:0]  one-hot output, bit sel_i set
// -----------------------------------------------------------------------------
module decodificador_N_M_dataflow #(
   parameter  int N = 4,
   localparam int M = 1 << N
) (
   input  logic [N-1:0] sel_i,
   output logic [M-1:0] y_o
);

   assign y_o = {{(M-1){1'b0}}, 1'b1} << sel_i;

endmodule

// File: rtl/arbitro_round_robin_n_m.sv
// -----------------------------------------------------------------------------
// arbitro_round_robin_n_m
// Round-robin arbiter sharing one resource among M = 2^N requesters.
// A two-state FSM holds the current grant; a rotating pointer sets the start
// of the circular search, and a hold counter forces rotation after HOLD_MAX
// consecutive cycles so no requester can starve the others.
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   req        [M-1:0] request vector, bit i = requester i
//   gnt        [M-1:0] one-hot grant, zero when idle (usable as select enable)
//   gnt_idx    [N-1:0] binary index of the grant, holds last value when idle
//   gnt_valid  high while a grant is active
// HOLD_MAX must lie in 1..255 (it is compared against an 8-bit counter).
// -----------------------------------------------------------------------------
module arbitro_round_robin_n_m
   import arbitro_pkg::*;
#(
   parameter  int N        = 4,
   parameter  int HOLD_MAX = 8,
   localparam int M        = 1 << N
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [M-1:0] req,
   output logic [M-1:0] gnt,
   output logic [N-1:0] gnt_idx,
   output logic         gnt_valid
);

   arb_state_e            state_q, state_d;
   logic [N-1:0]          ptr_q, ptr_d;
   logic [N-1:0]          idx_q, idx_d;
   logic                  valid_q, valid_d;
   logic [HOLD_CNT_W-1:0] hold_q, hold_d;

   logic [N-1:0]          idx_plus1;
   logic [N-1:0]          sel_from_ptr;
   logic [N-1:0]          sel_after_g;
   logic [M-1:0]          dec_out;

   // Wraps mod M for free because the sum is truncated to N bits.
   assign idx_plus1    = N'(idx_q + 1'b1);
   assign sel_from_ptr = N'(prox_req(MAX_M'(req), MAX_N'(ptr_q), M));
   assign sel_after_g  = N'(prox_req(MAX_M'(req), MAX_N'(idx_plus1), M));

   // NOTE: every signal driven here gets a default first, so no path leaves
   // one unassigned and no latch is inferred.
   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      idx_d   = idx_q;
      valid_d = valid_q;
      hold_d  = hold_q;
      unique case (state_q)
         ST_IDLE: begin
            if (|req) begin
               idx_d   = sel_from_ptr;
               valid_d = 1'b1;
               hold_d  = HOLD_CNT_W'(1);
               state_d = ST_GRANT;
            end
         end
         ST_GRANT: begin
            if (!req[idx_q]) begin
               // Holder released: hand over in the same edge if anyone else
               // waits, so there is no idle bubble between grants.
               ptr_d = idx_plus1;
               if (|req) begin
                  idx_d  = sel_after_g;
                  hold_d = HOLD_CNT_W'(1);
               end else begin
                  valid_d = 1'b0;
                  state_d = ST_IDLE;
               end
            end else if (hold_q == HOLD_CNT_W'(HOLD_MAX)) begin
               // Forced rotation; the search wraps back to the holder when
               // it is the only requester, so the grant stays up.
               ptr_d  = idx_plus1;
               idx_d  = sel_after_g;
               hold_d = HOLD_CNT_W'(1);
            end else begin
               hold_d = HOLD_CNT_W'(hold_q + 1'b1);
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
         ptr_q   <= '0;
         idx_q   <= '0;
         valid_q <= 1'b0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         idx_q   <= idx_d;
         valid_q <= valid_d;
         hold_q  <= hold_d;
      end
   end

   decodificador_N_M_dataflow #(.N(N)) u_dec (
      .sel_i (idx_q),
      .y_o   (dec_out)
   );

   // Registered state only: no combinational path from req to gnt.
   assign gnt       = dec_out & {M{valid_q}};
   assign gnt_idx   = idx_q;
   assign gnt_valid = valid_q;

endmodule
